// File: rtl/fsm_seq_detector.sv
// Serial pattern detector: shifts din into a history register and pulses match on each hit.
// Optional saturating match counter is built only when FSM_SEQ_MATCH_COUNT_EN is defined.
module fsm_seq_detector #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             overlap,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_count,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] FILL = 2'b01;
    localparam logic [1:0] SCAN = 2'b10;

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [1:0]        state_q, state_d;
    logic [PAT_W-1:0]  hist_q, hist_d, hist_s;
    logic [FILL_W-1:0] fill_q, fill_d, fill_s;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              match_q;
    logic              hit;

    // Post-sample history and fill, used both for hit detection and the next state.
    assign hist_s = {hist_q[PAT_W-2:0], din};
    assign fill_s = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        hit     = 1'b0;
        unique case (state_q)
            IDLE, FILL, SCAN: begin
                if (load) begin
                    // A load discards this cycle's sample entirely.
                    pat_d   = pat_in;
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = en ? FILL : IDLE;
                end else if (!en) begin
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = IDLE;
                end else begin
                    hit = (hist_s == pat_q) && (fill_s == FILL_FULL);
                    if (hit && !overlap) begin
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = FILL;
                    end else begin
                        hist_d  = hist_s;
                        fill_d  = fill_s;
                        state_d = (fill_s == FILL_FULL) ? SCAN : FILL;
                    end
                end
            end
            default: begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '1;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            match_q <= hit;
        end
    end

`ifdef FSM_SEQ_MATCH_COUNT_EN
    logic [CNT_W-1:0] count_q;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_count) begin
            count_q <= '0;
        end else if (hit && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign match_count = count_q;
`else
    logic unused_clr_count;
    assign unused_clr_count = clr_count;
    assign match_count      = '0;
`endif

    assign match = match_q;
    assign state = state_q;

endmodule

// File: tb/tb_fsm_seq_detector.sv
// Self-checking bench for fsm_seq_detector: directed vector table, hand corner cases and
// randomized traffic against a queue-based reference model.
module tb_fsm_seq_detector;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 8;
`ifdef FSM_SEQ_MATCH_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             din = 1'b0;
    logic             overlap = 1'b0;
    logic             load = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic             clr_count = 1'b0;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic [1:0]       state;

    fsm_seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .din         (din),
        .overlap     (overlap),
        .load        (load),
        .pat_in      (pat_in),
        .clr_count   (clr_count),
        .match       (match),
        .match_count (match_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the bits sampled since the last clear, newest at the back.
    bit         m_q[$];
    bit [3:0]   m_pat;
    int         m_cnt;
    bit         m_match;
    int         m_state;

    function automatic void model_reset();
        m_q.delete();
        m_pat   = 4'b1111;
        m_cnt   = 0;
        m_match = 1'b0;
        m_state = 0;
    endfunction

    function automatic void model_step(input bit e, d, o, l, input bit [3:0] p, input bit c);
        bit hit = 1'b0;
        if (l) begin
            m_pat = p;
            m_q.delete();
            m_state = e ? 1 : 0;
        end else if (!e) begin
            m_q.delete();
            m_state = 0;
        end else begin
            m_q.push_back(d);
            if (m_q.size() > PAT_W) void'(m_q.pop_front());
            if (m_q.size() == PAT_W) begin
                hit = 1'b1;
                for (int i = 0; i < PAT_W; i++)
                    if (m_q[i] != m_pat[PAT_W-1-i]) hit = 1'b0;
            end
            if (hit && !o) begin
                m_q.delete();
                m_state = 1;
            end else begin
                m_state = (m_q.size() == PAT_W) ? 2 : 1;
            end
        end
        m_match = hit;
        if (CNT_ON) begin
            if (c) m_cnt = 0;
            else if (hit && m_cnt < CNT_MAX) m_cnt++;
        end
    endfunction

    // Drive one cycle of inputs, clock it, and leave time at edge+1 for sampling.
    task automatic step(input bit e, d, o, l, input bit [3:0] p, input bit c);
        en = e; din = d; overlap = o; load = l; pat_in = p; clr_count = c;
        @(posedge clk);
        model_step(e, d, o, l, p, c);
        #1;
    endtask

    task automatic do_reset();
        en = 0; din = 0; load = 0; clr_count = 0; overlap = 0; pat_in = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit       e, d, o, l;
        bit [3:0] p;
        bit       c;
        bit       exp_m;
        bit [1:0] exp_st;
        int       exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit e, d, o, l, input bit [3:0] p, input bit c,
                       input bit em, input bit [1:0] es, input int ec);
        vec_t v;
        v.e = e; v.d = d; v.o = o; v.l = l; v.p = p; v.c = c;
        v.exp_m = em; v.exp_st = es; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        int pulses;
        model_reset();
        #2;
        chk("reset_match", int'(match), 0);
        chk("reset_count", int'(match_count), 0);
        chk("reset_state", int'(state), 0);
        do_reset();

        // Overlapping stream, then non-overlapping, en drop, load on completing bit.
        add(0, 0, 1, 1, 4'b1011, 0, 0, 2'b00, 0);
        add(1, 1, 1, 0, 0, 0, 0, 2'b01, 0);
        add(1, 0, 1, 0, 0, 0, 0, 2'b01, 0);
        add(1, 1, 1, 0, 0, 0, 0, 2'b01, 0);
        add(1, 1, 1, 0, 0, 0, 1, 2'b10, 1);
        add(1, 0, 1, 0, 0, 0, 0, 2'b10, 1);
        add(1, 1, 1, 0, 0, 0, 0, 2'b10, 1);
        add(1, 1, 1, 0, 0, 0, 1, 2'b10, 2);
        add(0, 0, 1, 0, 0, 0, 0, 2'b00, 2);
        add(0, 0, 0, 0, 0, 1, 0, 2'b00, 0);
        add(1, 1, 0, 0, 0, 0, 0, 2'b01, 0);
        add(1, 0, 0, 0, 0, 0, 0, 2'b01, 0);
        add(1, 1, 0, 0, 0, 0, 0, 2'b01, 0);
        add(1, 1, 0, 0, 0, 0, 1, 2'b01, 1);
        add(1, 0, 0, 0, 0, 0, 0, 2'b01, 1);
        add(1, 1, 0, 0, 0, 0, 0, 2'b01, 1);
        add(1, 1, 0, 0, 0, 0, 0, 2'b01, 1);
        add(0, 0, 1, 0, 0, 0, 0, 2'b00, 1);
        add(1, 1, 1, 0, 0, 0, 0, 2'b01, 1);
        add(1, 0, 1, 0, 0, 0, 0, 2'b01, 1);
        add(1, 1, 1, 0, 0, 0, 0, 2'b01, 1);
        add(0, 0, 1, 0, 0, 0, 0, 2'b00, 1);
        add(1, 1, 1, 0, 0, 0, 0, 2'b01, 1);
        add(0, 0, 1, 0, 0, 0, 0, 2'b00, 1);
        add(1, 1, 1, 0, 0, 0, 0, 2'b01, 1);
        add(1, 0, 1, 0, 0, 0, 0, 2'b01, 1);
        add(1, 1, 1, 0, 0, 0, 0, 2'b01, 1);
        add(1, 1, 1, 1, 4'b0000, 0, 0, 2'b01, 1);
        add(1, 0, 1, 0, 0, 0, 0, 2'b01, 1);
        add(1, 0, 1, 0, 0, 0, 0, 2'b01, 1);
        add(1, 0, 1, 0, 0, 0, 0, 2'b01, 1);
        add(1, 0, 1, 0, 0, 0, 1, 2'b10, 2);
        add(0, 0, 1, 0, 0, 0, 0, 2'b00, 2);

        foreach (vecs[i]) begin
            step(vecs[i].e, vecs[i].d, vecs[i].o, vecs[i].l, vecs[i].p, vecs[i].c);
            chk($sformatf("vec%0d_match", i), int'(match), int'(vecs[i].exp_m));
            chk($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].exp_st));
            chk($sformatf("vec%0d_count", i), int'(match_count),
                CNT_ON ? vecs[i].exp_cnt : 0);
        end

        // Saturation: 300 ones against 1111 with overlap.
        do_reset();
        step(0, 0, 1, 1, 4'b1111, 0);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            step(1, 1, 1, 0, 0, 0);
            if (match) pulses++;
        end
        chk("sat_pulses", pulses, 297);
        chk("sat_count", int'(match_count), CNT_ON ? 255 : 0);
        step(0, 0, 1, 0, 0, 0);
        chk("sat_no_pulse_after", int'(match), 0);

        // Clear has priority over a simultaneous hit; the pulse still appears.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1);
        chk("clr_hit_match", int'(match), 1);
        chk("clr_hit_count", int'(match_count), 0);
        step(1, 1, 1, 0, 0, 0);
        chk("after_clr_count", int'(match_count), CNT_ON ? 1 : 0);

        // Asynchronous reset while match is high and mid-stream.
        do_reset();
        step(0, 0, 1, 1, 4'b1011, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        chk("pre_rst_match", int'(match), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_match", int'(match), 0);
        chk("async_rst_count", int'(match_count), 0);
        chk("async_rst_state", int'(state), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0, 0, 0);
            chk($sformatf("post_rst_nomatch%0d", i), int'(match), 0);
        end
        step(1, 1, 1, 0, 0, 0);
        chk("post_rst_pat_ones", int'(match), 1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit e, d, o, l, c;
            bit [3:0] p;
            e = ($urandom_range(0, 7) != 0);
            d = $urandom_range(0, 1) == 1;
            o = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 31) == 0);
            c = ($urandom_range(0, 63) == 0);
            p = 4'($urandom_range(0, 15));
            step(e, d, o, l, p, c);
            chk($sformatf("rnd%0d_match", i), int'(match), int'(m_match));
            chk($sformatf("rnd%0d_state", i), int'(state), m_state);
            chk($sformatf("rnd%0d_count", i), int'(match_count), m_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
